// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end, counter and display stages:
// FSM encodings, 25 MHz default timing and a small constant helper.
package button_pkg;

    localparam logic [1:0] ST_RELEASED  = 2'd0;
    localparam logic [1:0] ST_HOLD_WAIT = 2'd1;
    localparam logic [1:0] ST_REPEAT    = 2'd2;

    localparam int DEFAULT_DEBOUNCE_TIME = 250_000;    // 10 ms
    localparam int DEFAULT_REPEAT_DELAY  = 12_500_000; // 500 ms
    localparam int DEFAULT_REPEAT_PERIOD = 2_500_000;  // 100 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus stability counter. Emits the debounced level and
// single-cycle rise/fall strobes that coincide with the edge that updates it.
module debounce_filter
    import button_pkg::*;
#(
    parameter int DEBOUNCE_TIME = DEFAULT_DEBOUNCE_TIME
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_TIME + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_TIME - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] count_r;
    logic          differ_s;
    logic          settle_s;

    assign differ_s = sync2_r ^ level_r;
    assign settle_s = differ_s & (count_r == COUNT_LAST);

    assign level = level_r;
    assign rise  = settle_s & ~level_r;
    assign fall  = settle_s &  level_r;

    // Synchronise the raw switch and accept a new level after a stable run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            count_r <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (!differ_s) begin
                count_r <= '0;
            end else if (settle_s) begin
                count_r <= '0;
                level_r <= ~level_r;
            end else begin
                count_r <= count_r + COUNT_ONE;
            end
        end
    end

endmodule

// File: rtl/button_repeat.sv
// Debounced push-button with a press pulse and typematic auto-repeat pulses.
// The debounce stage is a sub-module; this level holds the repeat FSM and timer.
module button_repeat
    import button_pkg::*;
#(
    parameter int DEBOUNCE_TIME = DEFAULT_DEBOUNCE_TIME,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Pressed,
    output logic o_Pulse,
    output logic o_Repeating
);

    localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam bit REPEAT_EN = (REPEAT_DELAY > 0);
    localparam int DELAY_LAST_I = REPEAT_EN ? (REPEAT_DELAY - 1) : 0;
    localparam logic [TW-1:0] DELAY_LAST  = TW'(DELAY_LAST_I);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

    logic          rise_s;
    logic          fall_s;
    logic [1:0]    state_r;
    logic [1:0]    state_nx;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nx;
    logic          pulse_r;
    logic          pulse_nx;
    logic          repeating_r;

    debounce_filter #(
        .DEBOUNCE_TIME(DEBOUNCE_TIME)
    ) u_debounce (
        .clk  (i_Clk),
        .rst_n(i_Rst_L),
        .raw  (i_Switch),
        .level(o_Pressed),
        .rise (rise_s),
        .fall (fall_s)
    );

    // Next-state logic; a debounced fall overrides any same-cycle timer expiry.
    always_comb begin
        state_nx = state_r;
        timer_nx = timer_r;
        pulse_nx = 1'b0;
        if (fall_s) begin
            state_nx = ST_RELEASED;
            timer_nx = '0;
        end else begin
            case (state_r)
                ST_RELEASED: begin
                    if (rise_s) begin
                        pulse_nx = 1'b1;
                        timer_nx = '0;
                        state_nx = ST_HOLD_WAIT;
                    end else begin
                        timer_nx = '0;
                    end
                end
                ST_HOLD_WAIT: begin
                    if (!REPEAT_EN) begin
                        timer_nx = timer_r;
                    end else if (timer_r == DELAY_LAST) begin
                        pulse_nx = 1'b1;
                        timer_nx = '0;
                        state_nx = ST_REPEAT;
                    end else begin
                        timer_nx = timer_r + TIMER_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (timer_r == PERIOD_LAST) begin
                        pulse_nx = 1'b1;
                        timer_nx = '0;
                    end else begin
                        timer_nx = timer_r + TIMER_ONE;
                    end
                end
                default: begin
                    state_nx = ST_RELEASED;
                    timer_nx = '0;
                end
            endcase
        end
    end

    // Register FSM state, timer and the pulse/repeat outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r     <= ST_RELEASED;
            timer_r     <= '0;
            pulse_r     <= 1'b0;
            repeating_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            timer_r     <= timer_nx;
            pulse_r     <= pulse_nx;
            repeating_r <= (state_nx == ST_REPEAT);
        end
    end

    assign o_Pulse     = pulse_r;
    assign o_Repeating = repeating_r;

endmodule
